pdpm_rx_req_parser: RTL and testbench

//  Sits between the Ethernet MAC RX FIFO (8-bit AXI-S, one frame per tlast) and the app/memory block.

---
 rtl/pdpm_rx_req_parser.sv | 215 +++++++++++++++++++++
 tb/tb_pdpm_rx_req_parser.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdpm_rx_req_parser.sv
// pdpm_rx_req_parser
// Parses pDPM request frames arriving from the MAC RX FIFO (8-bit stream,
// one frame per tlast). Each valid request produces one command. WRITE
// payload bytes are passed straight through to a downstream stream.
// Frames that do not match, or that are malformed, are counted and drained.
//
// Handshake rules: a byte moves on any stream when tvalid and tready are
// both high at a rising clock edge. A producer holds tvalid and its data
// stable until that happens. cmd_valid follows the same rule against
// cmd_ready, and the cmd_* fields stay stable while cmd_valid is high.
// No input byte is consumed while a command is pending, so commands and
// their payload leave the block in order.
module pdpm_rx_req_parser #(
  parameter logic [47:0] MAC_ADDR  = 48'h000A35000102,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        rx_fifo_clock,
  input  logic        rx_fifo_rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_addr,
  output logic [15:0] cmd_len,
  output logic [47:0] cmd_src_mac,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] drop_count,
  output logic        trunc_pulse,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam logic [7:0]  OP_READ   = 8'h01;
  localparam logic [7:0]  OP_WRITE  = 8'h02;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [4:0]  LAST_HDR  = 5'd20;

  state_t      r_state;
  logic [4:0]  r_byte_cnt;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic [15:0] r_etype;
  logic [7:0]  r_opcode;
  logic [31:0] r_addr;
  logic [7:0]  r_len_hi;
  logic        r_hdr_last;
  logic [15:0] r_remaining;

  logic [47:0] w_dst_full;
  logic [15:0] w_etype_full;
  logic        w_check_fail;
  logic        w_s_xfer;
  logic        w_pay_xfer;
  logic        w_drop_sat;

  assign dbg_state    = r_state;
  assign w_dst_full   = {r_dst[39:0], s_axis_tdata};
  assign w_etype_full = {r_etype[7:0], s_axis_tdata};
  assign w_s_xfer     = s_axis_tvalid & s_axis_tready;
  assign w_pay_xfer   = s_axis_tvalid & m_axis_tready;
  assign w_drop_sat   = (drop_count == 16'hFFFF);

  // Header checks on the byte that completes each checked field.
  always_comb begin
    w_check_fail = 1'b0;
    case (r_byte_cnt)
      5'd5:    w_check_fail = !((w_dst_full == MAC_ADDR) || (w_dst_full == BCAST_MAC));
      5'd13:   w_check_fail = (w_etype_full != ETHERTYPE);
      5'd14:   w_check_fail = !((s_axis_tdata == OP_READ) || (s_axis_tdata == OP_WRITE));
      default: w_check_fail = 1'b0;
    endcase
  end

  // Ready and pass-through paths, decoded from the current state.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    case (r_state)
      ST_HDR:   s_axis_tready = 1'b1;
      ST_CMD:   s_axis_tready = 1'b0;
      ST_PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = (r_remaining == 16'd1) | s_axis_tlast;
      end
      ST_DRAIN: s_axis_tready = 1'b1;
      default:  s_axis_tready = 1'b0;
    endcase
  end

  // Header field capture: big-endian shift into the field the byte belongs to.
  always_ff @(posedge rx_fifo_clock) begin
    if (rx_fifo_rst) begin
      r_dst    <= '0;
      r_src    <= '0;
      r_etype  <= '0;
      r_opcode <= '0;
      r_addr   <= '0;
      r_len_hi <= '0;
    end else if ((r_state == ST_HDR) && w_s_xfer) begin
      if (r_byte_cnt <= 5'd5) begin
        r_dst <= w_dst_full;
      end else if (r_byte_cnt <= 5'd11) begin
        r_src <= {r_src[39:0], s_axis_tdata};
      end else if (r_byte_cnt <= 5'd13) begin
        r_etype <= w_etype_full;
      end else if (r_byte_cnt == 5'd14) begin
        r_opcode <= s_axis_tdata;
      end else if (r_byte_cnt <= 5'd18) begin
        r_addr <= {r_addr[23:0], s_axis_tdata};
      end else if (r_byte_cnt == 5'd19) begin
        r_len_hi <= s_axis_tdata;
      end
    end
  end

  // Main frame FSM: header parse, command hand-off, payload, drain.
  always_ff @(posedge rx_fifo_clock) begin
    if (rx_fifo_rst) begin
      r_state     <= ST_HDR;
      r_byte_cnt  <= '0;
      r_hdr_last  <= 1'b0;
      r_remaining <= '0;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_src_mac <= '0;
      drop_count  <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= 1'b0;
      case (r_state)
        ST_HDR: begin
          if (w_s_xfer) begin
            if (r_byte_cnt == LAST_HDR) begin
              // Header complete: publish the command, remember if the frame ended here.
              cmd_valid   <= 1'b1;
              cmd_opcode  <= r_opcode;
              cmd_addr    <= r_addr;
              cmd_len     <= {r_len_hi, s_axis_tdata};
              cmd_src_mac <= r_src;
              r_hdr_last  <= s_axis_tlast;
              r_byte_cnt  <= '0;
              r_state     <= ST_CMD;
            end else if (w_check_fail || s_axis_tlast) begin
              // Bad field or short frame: count it, drain whatever is left.
              if (!w_drop_sat) begin
                drop_count <= drop_count + 16'd1;
              end
              r_byte_cnt <= '0;
              r_state    <= s_axis_tlast ? ST_HDR : ST_DRAIN;
            end else begin
              r_byte_cnt <= r_byte_cnt + 5'd1;
            end
          end
        end

        ST_CMD: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            if (r_hdr_last) begin
              // Frame ended on the last header byte: a WRITE lost its payload.
              if ((cmd_opcode == OP_WRITE) && (cmd_len != 16'd0)) begin
                trunc_pulse <= 1'b1;
              end
              r_state <= ST_HDR;
            end else if ((cmd_opcode == OP_READ) || (cmd_len == 16'd0)) begin
              r_state <= ST_DRAIN;
            end else begin
              r_remaining <= cmd_len;
              r_state     <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (w_pay_xfer) begin
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              // Last payload byte: anything after it is padding.
              r_state <= s_axis_tlast ? ST_HDR : ST_DRAIN;
            end else if (s_axis_tlast) begin
              trunc_pulse <= 1'b1;
              r_state     <= ST_HDR;
            end
          end
        end

        ST_DRAIN: begin
          if (w_s_xfer && s_axis_tlast) begin
            r_state <= ST_HDR;
          end
        end

        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_pdpm_rx_req_parser.sv
// tb_pdpm_rx_req_parser
// Directed frames with hand-computed commands and payload beats.
module tb_pdpm_rx_req_parser;

  localparam logic [47:0] MAC   = 48'h000A35000102;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC_A = 48'h021122334455;
  localparam logic [47:0] SRC_B = 48'h02AABBCCDDEE;
  localparam logic [15:0] ET    = 16'h88B5;

  // Clock / reset
  logic clk = 1'b0;
  logic rx_fifo_rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [47:0] cmd_src_mac;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [15:0] drop_count;
  logic        trunc_pulse;
  logic [1:0]  dbg_state;

  pdpm_rx_req_parser dut (
    .rx_fifo_clock (clk),
    .rx_fifo_rst   (rx_fifo_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_src_mac   (cmd_src_mac),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .drop_count    (drop_count),
    .trunc_pulse   (trunc_pulse),
    .dbg_state     (dbg_state)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [103:0] exp_cmd_q[$];
  logic [8:0]   exp_m_q[$];
  logic [7:0]   frm[$];
  int exp_drop  = 0;
  int exp_trunc = 0;
  int got_trunc = 0;
  int cmd_stall = 0;
  bit m_toggle  = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] mk_cmd(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [15:0] len, input logic [47:0] src);
    return {op, addr, len, src};
  endfunction

  // Downstream responders: command stall counter and m_axis_tready toggling.
  initial forever begin
    @(posedge clk); #1;
    if (cmd_stall > 0 && cmd_valid) begin
      cmd_ready = 1'b0;
      cmd_stall--;
    end else begin
      cmd_ready = 1'b1;
    end
    m_axis_tready = m_toggle ? ~m_axis_tready : 1'b1;
  end

  // Monitor: sampled mid-cycle, checks commands, beats and pulses in order.
  always @(negedge clk) begin
    if (!rx_fifo_rst) begin
      if (cmd_valid) begin
        check_eq("cmd_hold_s_tready", s_axis_tready, 1'b0);
        if (exp_cmd_q.size() == 0) begin
          check_eq("cmd_unexpected", cmd_valid, 1'b0);
        end else begin
          check_eq("cmd_fields", {cmd_opcode, cmd_addr, cmd_len, cmd_src_mac}, exp_cmd_q[0]);
          if (cmd_ready) void'(exp_cmd_q.pop_front());
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_m_q.size() == 0) begin
          check_eq("m_unexpected", {m_axis_tlast, m_axis_tdata}, 9'h1FF);
        end else begin
          check_eq("m_beat", {m_axis_tlast, m_axis_tdata}, exp_m_q.pop_front());
        end
      end
      if (trunc_pulse) got_trunc++;
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic ok;
    int waited;
    ok = 1'b0;
    waited = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk); #1;
      waited++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) check_eq("send_timeout", ok, 1'b1);
  endtask

  task automatic build_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                           input logic [7:0] op, input logic [31:0] addr, input logic [15:0] len);
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    frm.push_back(op);
    for (int i = 3; i >= 0; i--) frm.push_back(addr[i*8 +: 8]);
    frm.push_back(len[15:8]);
    frm.push_back(len[7:0]);
  endtask

  task automatic add_pay(input logic [7:0] b, input logic exp_last);
    frm.push_back(b);
    exp_m_q.push_back({exp_last, b});
  endtask

  task automatic pad_to(input int n);
    while (frm.size() < n) frm.push_back(8'h5A);
  endtask

  task automatic send_frm(input bit with_last);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], with_last && (i == frm.size() - 1));
    end
  endtask

  task automatic end_test(input string name);
    repeat (5) @(posedge clk);
    #1;
    check_eq({name, "_cmd_left"}, exp_cmd_q.size(), 0);
    check_eq({name, "_m_left"}, exp_m_q.size(), 0);
    check_eq({name, "_trunc"}, got_trunc, exp_trunc);
    check_eq({name, "_drop"}, drop_count, exp_drop);
    check_eq({name, "_idle_ready"}, s_axis_tready, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rx_fifo_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_valid", cmd_valid, 1'b0);
    check_eq("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_drop", drop_count, 16'd0);
    check_eq("rst_trunc", trunc_pulse, 1'b0);
    check_eq("rst_s_tready", s_axis_tready, 1'b1);
    check_eq("rst_cmd_fields", {cmd_opcode, cmd_addr, cmd_len, cmd_src_mac}, 104'd0);
    @(posedge clk); #1;

    // 1: WRITE len 4, unpadded
    build_hdr(MAC, SRC_A, ET, 8'h02, 32'h1000_0040, 16'd4);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h1000_0040, 16'd4, SRC_A));
    add_pay(8'hDE, 1'b0);
    add_pay(8'hAD, 1'b0);
    add_pay(8'hBE, 1'b0);
    add_pay(8'hEF, 1'b1);
    send_frm(1'b1);
    end_test("t1");

    // 2: READ len 64 padded to 60 bytes, then READ ending exactly on byte 20
    build_hdr(MAC, SRC_B, ET, 8'h01, 32'h0000_2000, 16'd64);
    exp_cmd_q.push_back(mk_cmd(8'h01, 32'h0000_2000, 16'd64, SRC_B));
    pad_to(60);
    send_frm(1'b1);
    build_hdr(BCAST, SRC_A, ET, 8'h01, 32'hCAFE_0008, 16'd8);
    exp_cmd_q.push_back(mk_cmd(8'h01, 32'hCAFE_0008, 16'd8, SRC_A));
    send_frm(1'b1);
    end_test("t2");

    // 3: drops (EtherType, dst, short, opcode, tlast on failing byte), then valid frame
    build_hdr(MAC, SRC_A, 16'h0800, 8'h02, 32'h0, 16'd4);
    pad_to(60);
    send_frm(1'b1);
    build_hdr(48'h112233445566, SRC_A, ET, 8'h02, 32'h0, 16'd4);
    pad_to(60);
    send_frm(1'b1);
    exp_drop = 2;
    end_test("t3a");
    build_hdr(MAC, SRC_A, ET, 8'h02, 32'h0, 16'd4);
    frm = frm[0:14];
    send_frm(1'b1);
    build_hdr(MAC, SRC_A, ET, 8'h07, 32'h0, 16'd4);
    pad_to(30);
    send_frm(1'b1);
    build_hdr(MAC, SRC_A, 16'h86DD, 8'h02, 32'h0, 16'd4);
    frm = frm[0:13];
    send_frm(1'b1);
    build_hdr(MAC, SRC_B, ET, 8'h02, 32'h0000_0300, 16'd0);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h0000_0300, 16'd0, SRC_B));
    pad_to(30);
    send_frm(1'b1);
    exp_drop = 5;
    end_test("t3b");

    // 4: truncated WRITE payload, then WRITE ending on the last header byte
    build_hdr(MAC, SRC_A, ET, 8'h02, 32'h0000_4000, 16'd8);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h0000_4000, 16'd8, SRC_A));
    add_pay(8'h01, 1'b0);
    add_pay(8'h02, 1'b0);
    add_pay(8'h03, 1'b1);
    send_frm(1'b1);
    exp_trunc = 1;
    build_hdr(MAC, SRC_B, ET, 8'h02, 32'h0000_5000, 16'd5);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h0000_5000, 16'd5, SRC_B));
    send_frm(1'b1);
    exp_trunc = 2;
    end_test("t4");

    // 5: command stalled 10 cycles, downstream ready toggling, padded WRITE
    cmd_stall = 10;
    m_toggle  = 1'b1;
    build_hdr(MAC, SRC_B, ET, 8'h02, 32'h8000_0010, 16'd6);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h8000_0010, 16'd6, SRC_B));
    for (int i = 0; i < 6; i++) add_pay(8'h30 + 8'(i), i == 5);
    pad_to(31);
    send_frm(1'b1);
    m_toggle = 1'b0;
    end_test("t5");
    check_eq("t5_stall_used", cmd_stall, 0);

    // 6: reset during payload, then a fresh frame
    build_hdr(MAC, SRC_A, ET, 8'h02, 32'h0000_6000, 16'd4);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h0000_6000, 16'd4, SRC_A));
    add_pay(8'h91, 1'b0);
    add_pay(8'h92, 1'b0);
    send_frm(1'b0);
    rx_fifo_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_rst_cmd_valid", cmd_valid, 1'b0);
    check_eq("t6_rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_eq("t6_rst_m_tlast", m_axis_tlast, 1'b0);
    check_eq("t6_rst_drop", drop_count, 16'd0);
    check_eq("t6_rst_trunc", trunc_pulse, 1'b0);
    check_eq("t6_rst_cmd_fields", {cmd_opcode, cmd_addr, cmd_len, cmd_src_mac}, 104'd0);
    check_eq("t6_rst_s_tready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    rx_fifo_rst = 1'b0;
    exp_drop = 0;
    build_hdr(BCAST, SRC_B, ET, 8'h02, 32'h0000_7000, 16'd2);
    exp_cmd_q.push_back(mk_cmd(8'h02, 32'h0000_7000, 16'd2, SRC_B));
    add_pay(8'h11, 1'b0);
    add_pay(8'h22, 1'b1);
    send_frm(1'b1);
    end_test("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
